pwm_meter: RTL and testbench

Measures the period and high time of a fixed-point analog waveform. A hysteresis comparator slices the signal to a digital level, and counters time that level in clock cycles. The block sits at the output of an emulated analog path such as the RLC filter bench, as the receiving end of a PWM stimulus. It reports each completed cycle with a one-cycle valid strobe so firmware or a trace probe can check the filter response against the stimulus.

---
 rtl/pwm_meter_pkg.sv | 18 +
 rtl/hyst_comp.sv | 64 ++++++
 rtl/pwm_meter.sv | 149 ++++++++++++++
 tb/tb_pwm_meter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_meter_pkg.sv
// pwm_meter_pkg: shared widths, debounce depth and FSM state type for pwm_meter.
// The debounce depth only matters when PWM_METER_DEBOUNCE_EN is defined.
package pwm_meter_pkg;

    localparam int DEF_WIDTH     = 18;
    localparam int DEF_CNT_WIDTH = 24;

    // Consecutive agreeing samples needed before the sliced level toggles.
    // The stability counter is 3 bits wide, so keep this between 1 and 8.
    localparam int DEBOUNCE      = 4;
    localparam int STAB_WIDTH    = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

endpackage

// File: rtl/hyst_comp.sv
// hyst_comp: hysteresis comparator that slices a signed fixed-point sample into
// a registered digital level. Optional debounce under PWM_METER_DEBOUNCE_EN.
module hyst_comp
    import pwm_meter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic signed [WIDTH-1:0] i_v_in,
    input  logic signed [WIDTH-1:0] i_th_hi,
    input  logic signed [WIDTH-1:0] i_th_lo,
    output logic                    o_dig_out
);

    logic r_dig_out;
    logic w_raw;

    // Only the threshold belonging to the current level is looked at, so
    // swapped thresholds simply collapse into a plain sign-style comparator.
    always_comb begin
        w_raw = r_dig_out;
        if (!r_dig_out && (i_v_in > i_th_hi)) begin
            w_raw = 1'b1;
        end else if (r_dig_out && (i_v_in < i_th_lo)) begin
            w_raw = 1'b0;
        end
    end

`ifdef PWM_METER_DEBOUNCE_EN
    localparam logic [STAB_WIDTH-1:0] STAB_LAST = STAB_WIDTH'(DEBOUNCE - 1);
    localparam logic [STAB_WIDTH-1:0] STAB_ONE  = STAB_WIDTH'(1);

    logic [STAB_WIDTH-1:0] r_stab;

    // Toggle only after the opposite decision has held for DEBOUNCE samples;
    // any sample agreeing with the current level restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dig_out <= 1'b0;
            r_stab    <= '0;
        end else if (w_raw == r_dig_out) begin
            r_stab    <= '0;
        end else if (r_stab == STAB_LAST) begin
            r_dig_out <= w_raw;
            r_stab    <= '0;
        end else begin
            r_stab    <= r_stab + STAB_ONE;
        end
    end
`else
    // Register the comparator decision directly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dig_out <= 1'b0;
        end else begin
            r_dig_out <= w_raw;
        end
    end
`endif

    assign o_dig_out = r_dig_out;

endmodule

// File: rtl/pwm_meter.sv
// pwm_meter: times the period and high time of a sliced analog waveform and
// strobes each completed cycle. Define PWM_METER_DEBOUNCE_EN to debounce the slicer.
module pwm_meter
    import pwm_meter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic signed [WIDTH-1:0] i_v_in,
    input  logic signed [WIDTH-1:0] i_th_hi,
    input  logic signed [WIDTH-1:0] i_th_lo,
    output logic                    o_dig_out,
    output logic [CNT_WIDTH-1:0]    o_period,
    output logic [CNT_WIDTH-1:0]    o_high_time,
    output logic                    o_meas_valid,
    output logic                    o_overflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    meter_state_t         r_state;
    meter_state_t         w_state_next;
    logic                 w_dig;
    logic                 r_dig_prev;
    logic                 w_rise;
    logic                 w_fall;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_hcnt;
    logic [CNT_WIDTH-1:0] r_hlat;
    logic                 r_fell;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_high_time;
    logic                 r_meas_valid;
    logic                 r_overflow;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] w_hcnt_next;
    logic [CNT_WIDTH-1:0] w_hlat_next;
    logic                 w_fell_next;
    logic [CNT_WIDTH-1:0] w_period_next;
    logic [CNT_WIDTH-1:0] w_high_time_next;
    logic                 w_meas_valid_next;
    logic                 w_overflow_next;

    hyst_comp #(
        .WIDTH (WIDTH)
    ) u_hyst_comp (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_v_in    (i_v_in),
        .i_th_hi   (i_th_hi),
        .i_th_lo   (i_th_lo),
        .o_dig_out (w_dig)
    );

    assign w_rise = w_dig & ~r_dig_prev;
    assign w_fall = ~w_dig & r_dig_prev;

    // Next-state and datapath decisions; a rise always beats counter saturation.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_hcnt_next       = r_hcnt;
        w_hlat_next       = r_hlat;
        w_fell_next       = r_fell;
        w_period_next     = r_period;
        w_high_time_next  = r_high_time;
        w_meas_valid_next = 1'b0;
        w_overflow_next   = r_overflow;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_cnt_next   = CNT_ONE;
                    w_hcnt_next  = CNT_ONE;
                    w_fell_next  = 1'b0;
                    w_state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_period_next     = r_cnt;
                    w_high_time_next  = r_fell ? r_hlat : r_cnt;
                    w_meas_valid_next = 1'b1;
                    w_cnt_next        = CNT_ONE;
                    w_hcnt_next       = CNT_ONE;
                    w_fell_next       = 1'b0;
                end else if (r_cnt == CNT_MAX) begin
                    w_overflow_next = 1'b1;
                    w_state_next    = IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                    if (w_dig && (r_hcnt != CNT_MAX)) begin
                        w_hcnt_next = r_hcnt + CNT_ONE;
                    end
                    if (w_fall) begin
                        w_hlat_next = r_hcnt;
                        w_fell_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Edge history, counters and the published measurement.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dig_prev   <= 1'b0;
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_hlat       <= '0;
            r_fell       <= 1'b0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_dig_prev   <= w_dig;
            r_cnt        <= w_cnt_next;
            r_hcnt       <= w_hcnt_next;
            r_hlat       <= w_hlat_next;
            r_fell       <= w_fell_next;
            r_period     <= w_period_next;
            r_high_time  <= w_high_time_next;
            r_meas_valid <= w_meas_valid_next;
            r_overflow   <= w_overflow_next;
        end
    end

    assign o_dig_out    = w_dig;
    assign o_period     = r_period;
    assign o_high_time  = r_high_time;
    assign o_meas_valid = r_meas_valid;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_pwm_meter.sv
// tb_pwm_meter: directed bench for pwm_meter with a 6-bit counter so that
// saturation is reachable. Also builds with PWM_METER_DEBOUNCE_EN defined.
module tb_pwm_meter;
    import pwm_meter_pkg::*;

    localparam int WIDTH     = 18;
    localparam int CNT_WIDTH = 6;

`ifdef PWM_METER_DEBOUNCE_EN
    localparam int EXTRA = DEBOUNCE - 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = 2 + EXTRA;

    // Fixed point with 1.0 = 2^14.
    localparam logic signed [WIDTH-1:0] POS_ONE   = 18'sd16384;
    localparam logic signed [WIDTH-1:0] NEG_ONE   = -18'sd16384;
    localparam logic signed [WIDTH-1:0] POS_HALF  = 18'sd8192;
    localparam logic signed [WIDTH-1:0] NEG_HALF  = -18'sd8192;
    localparam logic signed [WIDTH-1:0] POS_NOISE = 18'sd4915;
    localparam logic signed [WIDTH-1:0] NEG_NOISE = -18'sd4915;

    logic                    clk;
    logic                    rst;
    logic signed [WIDTH-1:0] vIn;
    logic signed [WIDTH-1:0] thHi;
    logic signed [WIDTH-1:0] thLo;
    logic                    digOut;
    logic [CNT_WIDTH-1:0]    period;
    logic [CNT_WIDTH-1:0]    highTime;
    logic                    measValid;
    logic                    overflow;

    int vectors;
    int miscompares;
    bit hist [0:511];

    pwm_meter #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_v_in       (vIn),
        .i_th_hi      (thHi),
        .i_th_lo      (thLo),
        .o_dig_out    (digOut),
        .o_period     (period),
        .o_high_time  (highTime),
        .o_meas_valid (measValid),
        .o_overflow   (overflow)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when the values disagree.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one sample (and reset level), clock it in, settle past the edge.
    task automatic applyStimulus(input logic signed [WIDTH-1:0] v, input logic r);
        vIn = v;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic signed [WIDTH-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(v, 1'b0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " dig_out"}, int'(digOut), 0);
        checkOutput({tag, " period"}, int'(period), 0);
        checkOutput({tag, " high_time"}, int'(highTime), 0);
        checkOutput({tag, " meas_valid"}, int'(measValid), 0);
        checkOutput({tag, " overflow"}, int'(overflow), 0);
    endtask

    task automatic doReset();
        applyStimulus(NEG_ONE, 1'b1);
        hold(NEG_ONE, 4);
    endtask

    // Square wave starting from a settled low level. The first rise only arms;
    // each later rise must strobe LAT cycles after its crossing sample.
    task automatic runSquare(input string tag, input int per, input int hi,
                             input int nPer, input bit noisy);
        int s;
        int expDig;
        int expValid;
        logic signed [WIDTH-1:0] v;
        s = 0;
        for (int p = 0; p < nPer; p++) begin
            for (int j = 0; j < per; j++) begin
                v = (j < hi) ? POS_ONE : NEG_ONE;
                if (noisy && (j == hi - 2)) v = POS_NOISE;
                if (noisy && (j == hi - 1)) v = NEG_NOISE;
                if (noisy && (j == per - 2)) v = NEG_NOISE;
                if (noisy && (j == per - 1)) v = POS_NOISE;
                hist[s] = (j < hi);
                applyStimulus(v, 1'b0);
                expDig   = (s >= EXTRA) ? int'(hist[s - EXTRA]) : 0;
                expValid = ((p > 0) && (j == LAT - 1)) ? 1 : 0;
                checkOutput({tag, " dig_out"}, int'(digOut), expDig);
                checkOutput({tag, " meas_valid"}, int'(measValid), expValid);
                if (expValid == 1) begin
                    checkOutput({tag, " period"}, int'(period), per);
                    checkOutput({tag, " high_time"}, int'(highTime), hi);
                end
                s++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        thHi        = POS_HALF;
        thLo        = NEG_HALF;
        vIn         = NEG_ONE;
        rst         = 1'b1;

        // Reset state.
        applyStimulus(NEG_ONE, 1'b1);
        applyStimulus(NEG_ONE, 1'b1);
        checkAllZero("reset");
        hold(NEG_ONE, 4);

        // Strict threshold boundaries.
        hold(POS_HALF, 6);
        checkOutput("equal th_hi", int'(digOut), 0);
        hold(POS_HALF + 18'sd1, 6);
        checkOutput("above th_hi", int'(digOut), 1);
        checkOutput("arming rise", int'(measValid), 0);
        hold(NEG_HALF, 6);
        checkOutput("equal th_lo", int'(digOut), 1);
        hold(NEG_HALF - 18'sd1, 6);
        checkOutput("below th_lo", int'(digOut), 0);
        doReset();

        // Basic square wave, then outputs hold between strobes.
        runSquare("basic", 20, 10, 4, 1'b0);
        hold(NEG_ONE, 10);
        checkOutput("hold meas_valid", int'(measValid), 0);
        checkOutput("hold period", int'(period), 20);
        checkOutput("hold high_time", int'(highTime), 10);
        doReset();

        // Duty cycle with noise inside the hysteresis band.
        runSquare("duty", 50, 13, 3, 1'b1);
        doReset();

        // Swapped thresholds behave as a plain comparator.
        thHi = NEG_HALF;
        thLo = POS_HALF;
        runSquare("inverted", 20, 10, 3, 1'b0);
        thHi = POS_HALF;
        thLo = NEG_HALF;
        doReset();

        // Rise on the same cycle the counter hits all-ones: rise wins.
        runSquare("edge63", 63, 30, 2, 1'b0);
        checkOutput("edge63 overflow", int'(overflow), 0);
        doReset();

`ifndef PWM_METER_DEBOUNCE_EN
        // Shortest measurable period.
        runSquare("p2", 2, 1, 4, 1'b0);
        doReset();
`endif

        // Reset during the low phase of a period discards the measurement.
        runSquare("prerst", 20, 6, 2, 1'b0);
        for (int j = 0; j < 20; j++) begin
            applyStimulus((j < 6) ? POS_ONE : NEG_ONE, (j == 7));
            if (j == 7) begin
                checkAllZero("midrst");
            end
        end
        runSquare("postrst", 20, 6, 3, 1'b0);
        doReset();

        // Held high after one rise: counter saturates, no strobe, sticky flag.
        for (int j = 0; j < 100; j++) begin
            applyStimulus(POS_ONE, 1'b0);
            checkOutput("sat meas_valid", int'(measValid), 0);
            if (j == LAT + 61) checkOutput("sat overflow early", int'(overflow), 0);
            if (j == LAT + 62) checkOutput("sat overflow set", int'(overflow), 1);
        end
        hold(NEG_ONE, 10);
        runSquare("postsat", 20, 10, 3, 1'b0);
        checkOutput("sticky overflow", int'(overflow), 1);
        doReset();
        checkOutput("overflow cleared", int'(overflow), 0);

`ifdef PWM_METER_DEBOUNCE_EN
        // A two-sample glitch must not reach the sliced level.
        hold(POS_ONE, 2);
        for (int j = 0; j < 8; j++) begin
            applyStimulus(NEG_ONE, 1'b0);
            checkOutput("glitch dig_out", int'(digOut), 0);
            checkOutput("glitch meas_valid", int'(measValid), 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
